// File: rtl/lap_memory.sv
// lap_memory -- circular store of stopwatch lap snapshots with a browsable display.
//
// Purpose: on each lap request the running time is captured into a DEPTH-entry
// circular buffer. A selection index, counted from the oldest retained lap,
// chooses which snapshot drives disp_out. disp_out is registered, so it shows
// the selected entry one cycle after the selection or the entry changes.
//
// Parameters: NDIG  number of 4-bit BCD digits per snapshot (1..8)
//             DEPTH number of stored laps, power of two (2..64)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   lap       single-cycle capture request
//   time_in   running time, digit 0 in bits [3:0]
//   sel_next  browse toward the newest lap (wraps to the oldest)
//   sel_prev  browse toward the oldest lap (wraps to the newest)
//   disp_out  registered snapshot of the selected lap, zero while empty
//   disp_idx  selected logical index, 0 = oldest retained lap
//   lap_cnt   number of retained laps, 0..DEPTH
//   empty     lap_cnt == 0
//   full      lap_cnt == DEPTH
//   ovf       sticky: a lap arrived while full (cleared only by rst)
//
// Build option: define LAP_MEMORY_OVERWRITE_EN to make a lap while full
// replace the oldest entry; otherwise such a lap is dropped.

module lap_memory #(
  parameter int NDIG  = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lap,
  input  logic [4*NDIG-1:0]          time_in,
  input  logic                       sel_next,
  input  logic                       sel_prev,
  output logic [4*NDIG-1:0]          disp_out,
  output logic [$clog2(DEPTH)-1:0]   disp_idx,
  output logic [$clog2(DEPTH):0]     lap_cnt,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 4 * NDIG;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW-1:0] IDX_ZERO = '0;
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] old_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] last_idx;
  logic          wr_en;

  assign empty    = (lap_cnt == '0);
  assign full     = (lap_cnt == CNT_FULL);
  // Highest valid logical index; only meaningful while not empty.
  assign last_idx = AW'(lap_cnt - CNT_ONE);
  // Logical index is relative to the oldest entry; power-of-two depth wraps for free.
  assign rd_addr  = old_ptr + disp_idx;

`ifdef LAP_MEMORY_OVERWRITE_EN
  assign wr_en = lap && !rst;
`else
  assign wr_en = lap && !rst && !full;
`endif

  // Storage: no reset; stale contents are masked by lap_cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= time_in;
    end
  end

  // Control: pointers, count, selection and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      old_ptr  <= '0;
      lap_cnt  <= '0;
      disp_idx <= '0;
      ovf      <= 1'b0;
    end else if (lap) begin
      // A lap swallows any selection pulse in the same cycle.
      if (!full) begin
        wr_ptr   <= wr_ptr + IDX_ONE;
        lap_cnt  <= lap_cnt + CNT_ONE;
        disp_idx <= lap_cnt[AW-1:0];
      end else begin
        ovf <= 1'b1;
`ifdef LAP_MEMORY_OVERWRITE_EN
        // When full wr_ptr == old_ptr, so this write replaced the oldest entry.
        wr_ptr   <= wr_ptr + IDX_ONE;
        old_ptr  <= old_ptr + IDX_ONE;
        disp_idx <= IDX_LAST;
`endif
      end
    end else if (!empty && (sel_next != sel_prev)) begin
      if (sel_next) begin
        disp_idx <= (disp_idx == last_idx) ? IDX_ZERO : disp_idx + IDX_ONE;
      end else begin
        disp_idx <= (disp_idx == IDX_ZERO) ? last_idx : disp_idx - IDX_ONE;
      end
    end
  end

  // Display register: one-cycle read of the currently selected entry.
  always_ff @(posedge clk) begin
    if (rst || empty) begin
      disp_out <= '0;
    end else begin
      disp_out <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_lap_memory.sv
// Randomized and directed bench for lap_memory with a queue-based lap model
// and a scoreboard that checks every cycle's outputs.
module tb_lap_memory;
  localparam int NDIG  = 4;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 4 * NDIG;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lap = 1'b0;
  logic [DW-1:0] time_in = '0;
  logic          sel_next = 1'b0;
  logic          sel_prev = 1'b0;
  logic [DW-1:0] disp_out;
  logic [AW-1:0] disp_idx;
  logic [AW:0]   lap_cnt;
  logic          empty, full, ovf;

  lap_memory #(.NDIG(NDIG), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lap(lap), .time_in(time_in),
    .sel_next(sel_next), .sel_prev(sel_prev),
    .disp_out(disp_out), .disp_idx(disp_idx), .lap_cnt(lap_cnt),
    .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          idx;
    bit          ovf;
    logic [31:0] disp;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] laps[$];   // model: retained laps, oldest first
  int            m_idx = 0;
  bit            m_ovf = 1'b0;
  int            tests = 0;
  int            fails = 0;

  function automatic logic [31:0] model_view();
    if (laps.size() == 0) return 32'd0;
    return 32'(laps[m_idx]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  // One clock of stimulus; the model's expected post-edge view is queued.
  task automatic step(input bit r, input bit l, input bit n, input bit p, input logic [DW-1:0] t);
    exp_t e;
    logic [31:0] shown;
    @(negedge clk);
    rst = r; lap = l; sel_next = n; sel_prev = p; time_in = t;
    shown = model_view();   // display lags the selection by one cycle
    if (r) begin
      laps.delete(); m_idx = 0; m_ovf = 1'b0; shown = 32'd0;
    end else if (l) begin
      if (laps.size() < DEPTH) begin
        laps.push_back(t); m_idx = laps.size() - 1;
      end else begin
        m_ovf = 1'b1;
`ifdef LAP_MEMORY_OVERWRITE_EN
        void'(laps.pop_front()); laps.push_back(t); m_idx = DEPTH - 1;
`endif
      end
    end else if (laps.size() > 0 && n != p) begin
      if (n) m_idx = (m_idx + 1) % laps.size();
      else   m_idx = (m_idx == 0) ? laps.size() - 1 : m_idx - 1;
    end
    e.cnt = laps.size(); e.idx = m_idx; e.ovf = m_ovf; e.disp = shown;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lap_cnt",  32'(lap_cnt),  32'(e.cnt));
        chk("disp_idx", 32'(disp_idx), 32'(e.idx));
        chk("empty",    32'(empty),    32'(e.cnt == 0));
        chk("full",     32'(full),     32'(e.cnt == DEPTH));
        chk("ovf",      32'(ovf),      32'(e.ovf));
        chk("disp_out", 32'(disp_out), e.disp);
      end
    end
  end

  initial begin
    // Basic capture
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 16'h0123);
    idle(2);
    // Three laps, browse backward with wrap
    step(1, 0, 0, 0, '0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, DW'(i));
    idle(1);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, '0); idle(1); end
    // Simultaneous next/prev leaves index alone
    step(0, 0, 1, 1, '0); idle(1);
    // lap with rst while holding 3 laps
    step(1, 1, 0, 0, 16'h0777); idle(2);
    // Empty browsing
    step(0, 0, 1, 0, '0); step(0, 0, 0, 1, '0); idle(1);
    // Four laps then lap + sel_next
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, DW'(16'h0010 + i));
    step(0, 1, 1, 0, 16'h0042); idle(2);
    // Nine laps into DEPTH=8, then inspect oldest and newest
    step(1, 0, 0, 0, '0);
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, DW'(i));
    idle(1);
    step(0, 0, 1, 0, '0); idle(1);   // wraps to index 0
    step(0, 0, 0, 1, '0); idle(1);   // back to index 7
    step(0, 1, 0, 1, 16'h0099); idle(2);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           DW'($urandom));
    end
    idle(2);
    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
